// File: rtl/exc_sequencer_pkg.sv
// Shared types and constants for the LEGv8 exception/interrupt sequencer.
package exc_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        HALT    = 2'd2
    } exc_state_t;

    localparam logic [3:0] ESR_NONE         = 4'd0;
    localparam logic [3:0] ESR_BAD_OPCODE   = 4'd1;
    localparam logic [3:0] ESR_IRQ          = 4'd2;
    localparam logic [3:0] ESR_DOUBLE_FAULT = 4'd3;
    localparam logic [3:0] ESR_BAD_ERET     = 4'd4;

    localparam logic [63:0] VECTOR_ADDR_DEFAULT = 64'h0000_0000_0000_00D8;
    localparam int unsigned IRQ_GRACE_DEFAULT   = 1;

endpackage

// File: rtl/exc_sequencer_if.sv
// Bundle between the core (decoder, PC mux, IRQ source) and the exception sequencer.
interface exc_sequencer_if;

    logic [63:0] pc_i;
    logic        not_an_instr_i;
    logic        eret_i;
    logic        irq_req_i;
    logic        irq_ack_o;
    logic        exc_o;
    logic [63:0] vector_o;
    logic [63:0] elr_o;
    logic [3:0]  esr_o;
    logic        in_handler_o;
    logic        halted_o;

    modport master (
        output pc_i, not_an_instr_i, eret_i, irq_req_i,
        input  irq_ack_o, exc_o, vector_o, elr_o, esr_o, in_handler_o, halted_o
    );

    modport slave (
        input  pc_i, not_an_instr_i, eret_i, irq_req_i,
        output irq_ack_o, exc_o, vector_o, elr_o, esr_o, in_handler_o, halted_o
    );

endinterface

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: redirects fetch to the handler vector on invalid
// opcodes, stray ERETs and IRQs, holds ELR/ESR, masks nested events and halts on
// a fault inside the handler.
module exc_sequencer
    import exc_sequencer_pkg::*;
#(
    parameter logic [63:0] VECTOR_ADDR = VECTOR_ADDR_DEFAULT,
    parameter int unsigned IRQ_GRACE   = IRQ_GRACE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    exc_sequencer_if.slave  bus
);

    localparam logic [2:0] GRACE_LOAD = 3'(IRQ_GRACE);

    exc_state_t  r_state;
    exc_state_t  w_nextState;
    logic [63:0] r_elr;
    logic [3:0]  r_esr;
    logic [2:0]  r_graceCnt;

    logic        w_exc;
    logic        w_irqAck;
    logic        w_capture;
    logic [3:0]  w_esrNext;
    logic        w_loadGrace;
    logic        w_irqTakeable;

    assign w_irqTakeable = bus.irq_req_i && (r_graceCnt == 3'd0);

    // State register; a synchronous reset from any state lands in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection with invalid opcode taking priority over ERET over IRQ.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN: begin
                if (bus.not_an_instr_i || bus.eret_i || w_irqTakeable) begin
                    w_nextState = HANDLER;
                end
            end
            HANDLER: begin
                if (bus.not_an_instr_i) begin
                    w_nextState = HALT;
                end else if (bus.eret_i) begin
                    w_nextState = RUN;
                end
            end
            HALT: begin
                w_nextState = HALT;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    // Per-cycle pulses and capture controls; everything is quiet while reset is held.
    always_comb begin
        w_exc       = 1'b0;
        w_irqAck    = 1'b0;
        w_capture   = 1'b0;
        w_esrNext   = r_esr;
        w_loadGrace = 1'b0;
        if (!reset) begin
            case (r_state)
                RUN: begin
                    if (bus.not_an_instr_i) begin
                        w_exc     = 1'b1;
                        w_capture = 1'b1;
                        w_esrNext = ESR_BAD_OPCODE;
                    end else if (bus.eret_i) begin
                        w_exc     = 1'b1;
                        w_capture = 1'b1;
                        w_esrNext = ESR_BAD_ERET;
                    end else if (w_irqTakeable) begin
                        w_exc     = 1'b1;
                        w_irqAck  = 1'b1;
                        w_capture = 1'b1;
                        w_esrNext = ESR_IRQ;
                    end
                end
                HANDLER: begin
                    if (bus.not_an_instr_i) begin
                        w_capture = 1'b1;
                        w_esrNext = ESR_DOUBLE_FAULT;
                    end else if (bus.eret_i) begin
                        w_loadGrace = 1'b1;
                    end
                end
                default: begin
                    w_exc = 1'b0;
                end
            endcase
        end
    end

    // ELR/ESR capture on event transitions and the post-ERET IRQ grace countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_elr      <= 64'd0;
            r_esr      <= ESR_NONE;
            r_graceCnt <= 3'd0;
        end else begin
            if (w_capture) begin
                r_elr <= bus.pc_i;
                r_esr <= w_esrNext;
            end
            if (w_loadGrace) begin
                r_graceCnt <= GRACE_LOAD;
            end else if ((r_state == RUN) && (r_graceCnt != 3'd0)) begin
                r_graceCnt <= r_graceCnt - 3'd1;
            end
        end
    end

    assign bus.exc_o        = w_exc;
    assign bus.irq_ack_o    = w_irqAck;
    assign bus.vector_o     = VECTOR_ADDR;
    assign bus.elr_o        = r_elr;
    assign bus.esr_o        = r_esr;
    assign bus.in_handler_o = (r_state == HANDLER);
    assign bus.halted_o     = (r_state == HALT);

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the sequencer.
module tb_exc_sequencer;

    localparam logic [63:0] VEC   = 64'h0000_0000_0000_00D8;
    localparam int          GRACE = 1;

    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;

    // Behavioural model of the sequencer's architectural state
    bit          mInHandler;
    bit          mHalted;
    logic [63:0] mElr;
    logic [3:0]  mEsr;
    int          mGraceLeft;
    bit          lastAck;

    exc_sequencer_if bus();

    exc_sequencer #(
        .VECTOR_ADDR (VEC),
        .IRQ_GRACE   (GRACE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns core clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, check the DUT against the model mid-cycle, then advance the model
    task automatic applyStimulus(input logic [63:0] pc, input logic nai, input logic er,
                                 input logic irq, input logic rst);
        bit expExc;
        bit expAck;
        bus.pc_i           = pc;
        bus.not_an_instr_i = nai;
        bus.eret_i         = er;
        bus.irq_req_i      = irq;
        reset              = rst;

        expExc = 1'b0;
        expAck = 1'b0;
        if (!rst && !mHalted && !mInHandler) begin
            if (nai || er) begin
                expExc = 1'b1;
            end else if (irq && mGraceLeft == 0) begin
                expExc = 1'b1;
                expAck = 1'b1;
            end
        end
        lastAck = expAck;

        @(negedge clk);
        checkOutput("exc",       {63'd0, bus.exc_o},        {63'd0, expExc});
        checkOutput("irq_ack",   {63'd0, bus.irq_ack_o},    {63'd0, expAck});
        checkOutput("elr",       bus.elr_o,                 mElr);
        checkOutput("esr",       {60'd0, bus.esr_o},        {60'd0, mEsr});
        checkOutput("inHandler", {63'd0, bus.in_handler_o}, {63'd0, mInHandler});
        checkOutput("halted",    {63'd0, bus.halted_o},     {63'd0, mHalted});
        checkOutput("vector",    bus.vector_o,              VEC);

        @(posedge clk);
        if (rst) begin
            mInHandler = 0;
            mHalted    = 0;
            mElr       = 64'd0;
            mEsr       = 4'd0;
            mGraceLeft = 0;
        end else if (mHalted) begin
            mHalted = 1;
        end else if (mInHandler) begin
            if (nai) begin
                mElr       = pc;
                mEsr       = 4'd3;
                mInHandler = 0;
                mHalted    = 1;
            end else if (er) begin
                mInHandler = 0;
                mGraceLeft = GRACE;
            end
        end else begin
            if (nai) begin
                mElr = pc; mEsr = 4'd1; mInHandler = 1;
            end else if (er) begin
                mElr = pc; mEsr = 4'd4; mInHandler = 1;
            end else if (expAck) begin
                mElr = pc; mEsr = 4'd2; mInHandler = 1;
            end
            if (mGraceLeft > 0) mGraceLeft--;
        end
        #1;
    endtask

    initial begin
        logic [63:0] rpc;
        bit          irqLine;
        bit          rnai;
        bit          rer;
        bit          rrst;
        int          haltCycles;
        int          pick;

        checkCount = 0;
        errorCount = 0;
        mInHandler = 0;
        mHalted    = 0;
        mElr       = 64'd0;
        mEsr       = 4'd0;
        mGraceLeft = 0;
        lastAck    = 0;
        reset      = 1'b1;
        bus.pc_i           = 64'd0;
        bus.not_an_instr_i = 1'b0;
        bus.eret_i         = 1'b0;
        bus.irq_req_i      = 1'b0;

        @(posedge clk);
        #1;
        applyStimulus(64'h0, 0, 0, 0, 1);
        applyStimulus(64'h0, 0, 0, 0, 1);
        checkOutput("reset_elr",  bus.elr_o, 64'd0);
        checkOutput("reset_halt", {63'd0, bus.halted_o}, 64'd0);

        $display("[TB] invalid opcode from RUN");
        applyStimulus(64'h40, 1, 0, 0, 0);
        checkOutput("t1_elr", bus.elr_o, 64'h40);
        checkOutput("t1_esr", {60'd0, bus.esr_o}, 64'd1);
        checkOutput("t1_inh", {63'd0, bus.in_handler_o}, 64'd1);

        $display("[TB] IRQ held in handler, taken after ERET plus grace");
        applyStimulus(64'h44, 0, 0, 1, 0);
        applyStimulus(64'h48, 0, 1, 1, 0);
        checkOutput("t3_inh", {63'd0, bus.in_handler_o}, 64'd0);
        applyStimulus(64'h4c, 0, 0, 1, 0);
        checkOutput("t3_graceNoAck", {63'd0, lastAck}, 64'd0);
        applyStimulus(64'h100, 0, 0, 1, 0);
        checkOutput("t2_elr", bus.elr_o, 64'h100);
        checkOutput("t2_esr", {60'd0, bus.esr_o}, 64'd2);
        applyStimulus(64'h104, 0, 0, 0, 0);
        applyStimulus(64'h108, 0, 1, 0, 0);
        applyStimulus(64'h10c, 0, 0, 0, 0);
        applyStimulus(64'h110, 0, 0, 0, 0);

        $display("[TB] ERET outside handler");
        applyStimulus(64'h80, 0, 1, 0, 0);
        checkOutput("t5_elr", bus.elr_o, 64'h80);
        checkOutput("t5_esr", {60'd0, bus.esr_o}, 64'd4);

        $display("[TB] double fault halts");
        applyStimulus(64'h200, 1, 0, 0, 0);
        checkOutput("t4_elr", bus.elr_o, 64'h200);
        checkOutput("t4_esr", {60'd0, bus.esr_o}, 64'd3);
        checkOutput("t4_halt", {63'd0, bus.halted_o}, 64'd1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(64'h204 + 64'(i * 4), 1'(i % 3 == 0), 1'(i % 3 == 1), 1, 0);
        end
        checkOutput("t4_stillHalt", {63'd0, bus.halted_o}, 64'd1);
        applyStimulus(64'h0, 0, 0, 0, 1);
        checkOutput("t4_rstHalt", {63'd0, bus.halted_o}, 64'd0);
        checkOutput("t4_rstEsr", {60'd0, bus.esr_o}, 64'd0);

        $display("[TB] invalid opcode beats simultaneous IRQ");
        applyStimulus(64'h300, 1, 0, 1, 0);
        checkOutput("t6_noAck", {63'd0, lastAck}, 64'd0);
        checkOutput("t6_esr", {60'd0, bus.esr_o}, 64'd1);
        applyStimulus(64'h304, 0, 1, 1, 0);
        applyStimulus(64'h308, 0, 0, 1, 0);
        applyStimulus(64'h30c, 0, 0, 1, 0);
        checkOutput("t6_lateAck", {63'd0, lastAck}, 64'd1);

        $display("[TB] reset inside handler with IRQ pending");
        applyStimulus(64'h310, 0, 0, 1, 1);
        applyStimulus(64'h314, 0, 0, 1, 1);
        checkOutput("t7_inh", {63'd0, bus.in_handler_o}, 64'd0);
        applyStimulus(64'h318, 0, 0, 1, 0);
        checkOutput("t7_ack", {63'd0, lastAck}, 64'd1);
        applyStimulus(64'h31c, 0, 0, 0, 0);

        $display("[TB] random traffic");
        irqLine    = 0;
        haltCycles = 0;
        for (int i = 0; i < 600; i++) begin
            rpc = {$urandom, $urandom} & ~64'h3;
            if (!irqLine && $urandom_range(0, 5) == 0) irqLine = 1;
            pick = $urandom_range(0, 15);
            rnai = (pick < 2);
            rer  = (pick == 2 || pick == 3);
            haltCycles = mHalted ? haltCycles + 1 : 0;
            rrst = (haltCycles > 4) || ($urandom_range(0, 79) == 0);
            applyStimulus(rpc, rnai, rer, irqLine, rrst);
            if (lastAck) irqLine = 0;
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
